// File: rtl/wb_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_port_arbiter_pkg
// Description : Shared widths, source IDs and defaults for the writeback
//               port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_port_arbiter_pkg;

    localparam int c_GPR_AW       = 5;
    localparam int c_DATA_W       = 32;
    localparam int c_NUM_GPR      = 32;
    localparam int c_STARVE_LIMIT = 3;

    localparam logic [0:0] SRC_EXU = 1'b0;
    localparam logic [0:0] SRC_LSU = 1'b1;

    // x0 is hardwired zero, so it can never be written or marked busy.
    function automatic logic is_real_rd(input logic [c_GPR_AW-1:0] rd);
        return |rd;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wb_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : wb_port_arbiter_if
// Description : Writeback sources, decode hazard query and GPR write port.
// Revision    : 1.0 - initial release
// ============================================================================
interface wb_port_arbiter_if;
    import wb_port_arbiter_pkg::*;

    logic                exu_valid_i;
    logic                exu_ready_o;
    logic [c_GPR_AW-1:0] exu_rd_i;
    logic [c_DATA_W-1:0] exu_data_i;
    logic                exu_regw_i;

    logic                lsu_valid_i;
    logic                lsu_ready_o;
    logic [c_GPR_AW-1:0] lsu_rd_i;
    logic [c_DATA_W-1:0] lsu_data_i;

    logic                issue_load_i;
    logic [c_GPR_AW-1:0] issue_rd_i;
    logic [c_GPR_AW-1:0] rs1_i;
    logic [c_GPR_AW-1:0] rs2_i;
    logic                rs1_busy_o;
    logic                rs2_busy_o;

    logic                rf_we_o;
    logic [c_GPR_AW-1:0] rf_waddr_o;
    logic [c_DATA_W-1:0] rf_wdata_o;

    modport master (
        output exu_valid_i, exu_rd_i, exu_data_i, exu_regw_i,
        output lsu_valid_i, lsu_rd_i, lsu_data_i,
        output issue_load_i, issue_rd_i, rs1_i, rs2_i,
        input  exu_ready_o, lsu_ready_o, rs1_busy_o, rs2_busy_o,
        input  rf_we_o, rf_waddr_o, rf_wdata_o
    );

    modport slave (
        input  exu_valid_i, exu_rd_i, exu_data_i, exu_regw_i,
        input  lsu_valid_i, lsu_rd_i, lsu_data_i,
        input  issue_load_i, issue_rd_i, rs1_i, rs2_i,
        output exu_ready_o, lsu_ready_o, rs1_busy_o, rs2_busy_o,
        output rf_we_o, rf_waddr_o, rf_wdata_o
    );

endinterface
`default_nettype wire

// File: rtl/wb_port_arbiter_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : wb_busy_scoreboard
// Description : One busy bit per GPR for outstanding loads, two read ports.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_busy_scoreboard
    import wb_port_arbiter_pkg::*;
(
    input  wire logic                clk,
    input  wire logic                rst,
    input  wire logic                i_set_en,
    input  wire logic [c_GPR_AW-1:0] i_set_addr,
    input  wire logic                i_clr_en,
    input  wire logic [c_GPR_AW-1:0] i_clr_addr,
    input  wire logic [c_GPR_AW-1:0] i_rs1_addr,
    input  wire logic [c_GPR_AW-1:0] i_rs2_addr,
    output logic                     o_rs1_busy,
    output logic                     o_rs2_busy
);

    logic [c_NUM_GPR-1:0] r_busy;
    logic [c_NUM_GPR-1:0] w_busy_nxt;

    // Set is applied after clear so a reissued load to the same rd stays busy.
    always_comb begin
        w_busy_nxt = r_busy;
        if (i_clr_en) w_busy_nxt[i_clr_addr] = 1'b0;
        if (i_set_en) w_busy_nxt[i_set_addr] = 1'b1;
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) r_busy <= '0;
        else     r_busy <= w_busy_nxt;
    end

    assign o_rs1_busy = r_busy[i_rs1_addr];
    assign o_rs2_busy = r_busy[i_rs2_addr];

endmodule
`default_nettype wire

// File: rtl/wb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : wb_port_arbiter
// Description : Shares the GPR write port between EXU and LSU writeback with
//               starvation-bounded priority and a load busy scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = c_STARVE_LIMIT,
    parameter int CNT_W        = 2
) (
    input  wire logic          clk,
    input  wire logic          rst,
    wb_port_arbiter_if.slave   bus
);

    localparam logic [CNT_W-1:0] c_LIMIT      = CNT_W'(STARVE_LIMIT);
    localparam logic [0:0]       S_PRIO_EXU   = SRC_EXU;
    localparam logic [0:0]       S_PRIO_LSU   = SRC_LSU;

    logic [0:0]          r_state;
    logic [0:0]          w_state_nxt;
    logic                w_exu_gnt;
    logic                w_lsu_gnt;
    logic [CNT_W-1:0]    r_exu_cnt;
    logic [CNT_W-1:0]    r_lsu_cnt;
    logic [CNT_W-1:0]    w_exu_cnt_nxt;
    logic [CNT_W-1:0]    w_lsu_cnt_nxt;
    logic                r_rf_we;
    logic [c_GPR_AW-1:0] r_rf_waddr;
    logic [c_DATA_W-1:0] r_rf_wdata;
    logic                w_rf_we_nxt;
    logic [c_GPR_AW-1:0] w_rf_waddr_nxt;
    logic [c_DATA_W-1:0] w_rf_wdata_nxt;

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_PRIO_LSU;
        else     r_state <= w_state_nxt;
    end

    // Priority is decided from next-cycle counter values so a starved source
    // wins in the very cycle after its wait reaches the limit.
    always_comb begin
        w_state_nxt = S_PRIO_LSU;
        if (w_lsu_cnt_nxt == c_LIMIT)      w_state_nxt = S_PRIO_LSU;
        else if (w_exu_cnt_nxt == c_LIMIT) w_state_nxt = S_PRIO_EXU;
    end

    always_comb begin
        w_exu_gnt = bus.exu_valid_i & (~bus.lsu_valid_i | (r_state == S_PRIO_EXU));
        w_lsu_gnt = bus.lsu_valid_i & (~bus.exu_valid_i | (r_state == S_PRIO_LSU));
    end

    always_comb begin
        w_exu_cnt_nxt = '0;
        w_lsu_cnt_nxt = '0;
        if (bus.exu_valid_i && !w_exu_gnt)
            w_exu_cnt_nxt = (r_exu_cnt == c_LIMIT) ? r_exu_cnt : r_exu_cnt + CNT_W'(1);
        if (bus.lsu_valid_i && !w_lsu_gnt)
            w_lsu_cnt_nxt = (r_lsu_cnt == c_LIMIT) ? r_lsu_cnt : r_lsu_cnt + CNT_W'(1);
    end

    always_comb begin
        w_rf_we_nxt    = 1'b0;
        w_rf_waddr_nxt = r_rf_waddr;
        w_rf_wdata_nxt = r_rf_wdata;
        if (w_exu_gnt) begin
            w_rf_we_nxt    = bus.exu_regw_i & is_real_rd(bus.exu_rd_i);
            w_rf_waddr_nxt = bus.exu_rd_i;
            w_rf_wdata_nxt = bus.exu_data_i;
        end else if (w_lsu_gnt) begin
            w_rf_we_nxt    = is_real_rd(bus.lsu_rd_i);
            w_rf_waddr_nxt = bus.lsu_rd_i;
            w_rf_wdata_nxt = bus.lsu_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_exu_cnt  <= '0;
            r_lsu_cnt  <= '0;
            r_rf_we    <= 1'b0;
            r_rf_waddr <= '0;
            r_rf_wdata <= '0;
        end else begin
            r_exu_cnt  <= w_exu_cnt_nxt;
            r_lsu_cnt  <= w_lsu_cnt_nxt;
            r_rf_we    <= w_rf_we_nxt;
            r_rf_waddr <= w_rf_waddr_nxt;
            r_rf_wdata <= w_rf_wdata_nxt;
        end
    end

    wb_busy_scoreboard u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .i_set_en   (bus.issue_load_i & is_real_rd(bus.issue_rd_i)),
        .i_set_addr (bus.issue_rd_i),
        .i_clr_en   (w_lsu_gnt),
        .i_clr_addr (bus.lsu_rd_i),
        .i_rs1_addr (bus.rs1_i),
        .i_rs2_addr (bus.rs2_i),
        .o_rs1_busy (bus.rs1_busy_o),
        .o_rs2_busy (bus.rs2_busy_o)
    );

    assign bus.exu_ready_o = w_exu_gnt;
    assign bus.lsu_ready_o = w_lsu_gnt;
    assign bus.rf_we_o     = r_rf_we;
    assign bus.rf_waddr_o  = r_rf_waddr;
    assign bus.rf_wdata_o  = r_rf_wdata;

endmodule
`default_nettype wire
